signed_divider: RTL and testbench
=================================

Name: signed_divider

Overview:
- Sequential signed integer divider; the inverse of the team's sequential signed multiplier.
- Takes two WIDTH-bit two's-complement operands and produces the quotient and remainder in sign-magnitude form. Outputs are a magnitude plus a sign bit, matching the multiplier's product/sign/zflag output style.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Self-sequenced with a start/busy/done handshake; no external shift or register enables.

Parameters:
- WIDTH, 8, operand width in bits (two's complement). Must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- dividend  input  WIDTH  signed dividend, sampled only when start is accepted
- divisor  input  WIDTH  signed divisor, sampled only when start is accepted
- start  input  1  request a division; accepted only in IDLE
- busy  output  1  high while state ≠ IDLE
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  |quotient| magnitude (128 fits for WIDTH=8)
- q_sign  output  1  quotient sign (1 = negative)
- remainder  output  WIDTH-1  |remainder| magnitude
- r_sign  output  1  remainder sign (1 = negative)
- zflag  output  1  high when quotient magnitude == 0
- dbz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. busy, done, quotient, q_sign, remainder, r_sign and dbz all go to 0; zflag=1.
- Reset has priority over every other event, including mid-division. The operation is abandoned and no done pulse is produced.
- Rounding: truncation toward zero. dividend = q·divisor + r, with |r| < |divisor|.
- Sign of remainder: r has the sign of the dividend.
- Sign rules:
  - q_sign = dividend[MSB] ^ divisor[MSB], forced to 0 if the quotient magnitude is 0.
  - r_sign = dividend[MSB], forced to 0 if the remainder magnitude is 0.
- Magnitudes: taken with the codebase's existing twos_complement block. The most negative value maps to its unsigned magnitude 2^(WIDTH-1).
- FSM states: IDLE, DIVIDE, DONE.
  - IDLE, start=1, divisor≠0: latch |dividend|, |divisor| and both sign bits. Clear the partial remainder and the iteration counter. Go to DIVIDE.
  - IDLE, start=1, divisor==0: set dbz=1, quotient=0, remainder=0, q_sign=0, r_sign=0, zflag=1. Go to DONE; done is asserted the next cycle.
  - IDLE, start=0: hold all outputs.
  - DIVIDE: WIDTH iterations, one per clock.
    - Each iteration shifts {partial remainder, dividend} left by 1.
    - Trial subtract: if the result is ≥ 0, keep it and shift in quotient bit 1; else restore and shift in 0.
    - After iteration WIDTH, go to DONE.
  - DONE: done=1 for exactly one cycle. quotient, remainder, signs, zflag and dbz are updated on the edge entering DONE. Next state is IDLE.
- dbz clears on the next accepted start whose divisor is non-zero.
- Latency: start accepted at edge 0 → done high in the cycle after edge WIDTH (8 cycles for WIDTH=8). Divide-by-zero: done high in the cycle after edge 0.
- Result outputs are stable from done until the edge that accepts the next start.
- Start while busy (DIVIDE or DONE) is ignored and not queued. Operand changes during DIVIDE have no effect.
- Back-to-back: start may be asserted in the DONE cycle but is ignored there. It is accepted the following cycle (IDLE).

Decomposition:
- Shared package: WIDTH default, FSM state encoding (IDLE, DIVIDE, DONE), and the counter width $clog2(WIDTH+1).
- One sub-module, unsigned_divider: the magnitude-only shift-subtract datapath plus iteration counter. It mirrors unsigned_multiplier.
- The top level owns sign handling, twos_complement instances, divide-by-zero bypass and the handshake FSM.

Test Plan:
1. 100 / 7: start for 1 cycle → done 8 cycles later; quotient=14, q_sign=0, remainder=2, r_sign=0, zflag=0, dbz=0.
2. -100 / 7: quotient=14, q_sign=1, remainder=2, r_sign=1. Also -100 / -7: quotient=14, q_sign=0, remainder=2, r_sign=1.
3. -128 / -1: quotient=8'h80, q_sign=0, remainder=0, r_sign=0. Also -128 / 1: quotient=8'h80, q_sign=1.
4. 5 / -9: quotient=0, zflag=1, q_sign=0, remainder=5, r_sign=0. Also -5 / 9: r_sign=1, q_sign=0.
5. 37 / 0: done in the cycle after start; dbz=1, quotient=0, remainder=0, zflag=1. A following 9 / 3 gives quotient=3, dbz=0.
6. Control events:
   - Start 100/7, then pulse start with 50/5 at iteration 3 → ignored; result is still 14 r 2.
   - Start again and assert rst at iteration 4 → next cycle busy=0, done never pulses, all outputs at reset values.

Source files
------------

// File: rtl/signed_divider_pkg.sv
// Shared definitions for the signed divider: default width, FSM encoding and
// iteration counter sizing.
package signed_divider_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Operand/result bundle of the signed divider; master issues divisions,
// slave is the divider.
interface signed_divider_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic             q_sign;
  logic [WIDTH-2:0] remainder;
  logic             r_sign;
  logic             zflag;
  logic             dbz;

  modport master (
    output dividend, divisor, start,
    input  busy, done, quotient, q_sign, remainder, r_sign, zflag, dbz
  );

  modport slave (
    input  dividend, divisor, start,
    output busy, done, quotient, q_sign, remainder, r_sign, zflag, dbz
  );
endinterface

// File: rtl/twos_complement.sv
// Two's-complement negation; the most negative value maps onto itself, which
// read as unsigned is its magnitude.
module twos_complement #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] neg_o
);
  assign neg_o = ~value_i + WIDTH'(1);
endmodule

// File: rtl/unsigned_divider.sv
// Magnitude-only restoring divider: one quotient bit per run cycle. The
// dividend register fills with quotient bits as it shifts out.
module unsigned_divider
  import signed_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] dvd_mag_i,
  input  logic [WIDTH-1:0] dvsr_mag_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-2:0] rem_o
);
  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-2:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-2:0] diff;
  logic             ge;

  // Partial remainder is always below the divisor (<= 2^(WIDTH-1)), so it fits
  // WIDTH-1 bits; the trial subtract is a compare plus a modular difference.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    ge     = rem_sh >= dvsr_q;
    diff   = rem_sh[WIDTH-2:0] - dvsr_q[WIDTH-2:0];
    quo_o  = {dvd_q[WIDTH-2:0], ge};
    rem_o  = ge ? diff : rem_sh[WIDTH-2:0];
    last_o = cnt_q == CW'(WIDTH - 1);

    dvd_d  = dvd_q;
    dvsr_d = dvsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    if (load) begin
      dvd_d  = dvd_mag_i;
      dvsr_d = dvsr_mag_i;
      rem_d  = '0;
      cnt_d  = '0;
    end else if (run) begin
      dvd_d  = quo_o;
      rem_d  = rem_o;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvsr_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      dvd_q  <= dvd_d;
      dvsr_q <= dvsr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider with sign-magnitude results. Owns the handshake
// FSM, operand magnitudes, sign rules and the divide-by-zero bypass.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  signed_divider_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-2:0] remainder_q, remainder_d;
  logic             q_sign_q, q_sign_d;
  logic             r_sign_q, r_sign_d;
  logic             zflag_q, zflag_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [WIDTH-1:0] dvd_neg, dvsr_neg, dvd_mag, dvsr_mag;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-2:0] rem_nx;
  logic             load, run, last;

  twos_complement #(.WIDTH(WIDTH)) u_dvd_neg  (.value_i(bus.dividend), .neg_o(dvd_neg));
  twos_complement #(.WIDTH(WIDTH)) u_dvsr_neg (.value_i(bus.divisor),  .neg_o(dvsr_neg));

  assign dvd_mag  = bus.dividend[WIDTH-1] ? dvd_neg  : bus.dividend;
  assign dvsr_mag = bus.divisor[WIDTH-1]  ? dvsr_neg : bus.divisor;

  unsigned_divider #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .run       (run),
    .dvd_mag_i (dvd_mag),
    .dvsr_mag_i(dvsr_mag),
    .last_o    (last),
    .quo_o     (quo_nx),
    .rem_o     (rem_nx)
  );

  always_comb begin
    state_d     = state_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    q_sign_d    = q_sign_q;
    r_sign_d    = r_sign_q;
    zflag_d     = zflag_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    load        = 1'b0;
    run         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
            q_sign_d    = 1'b0;
            r_sign_d    = 1'b0;
            zflag_d     = 1'b1;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            load    = 1'b1;
            dbz_d   = 1'b0;
            q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_d = bus.dividend[WIDTH-1];
            state_d = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        run = 1'b1;
        // Results are taken from the final iteration's combinational step so
        // they land on the same edge that enters DONE.
        if (last) begin
          quotient_d  = quo_nx;
          remainder_d = rem_nx;
          q_sign_d    = q_neg_q & (|quo_nx);
          r_sign_d    = r_neg_q & (|rem_nx);
          zflag_d     = ~(|quo_nx);
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      q_sign_q    <= 1'b0;
      r_sign_q    <= 1'b0;
      zflag_q     <= 1'b1;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      q_sign_q    <= q_sign_d;
      r_sign_q    <= r_sign_d;
      zflag_q     <= zflag_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
    end
  end

  assign bus.busy      = state_q != ST_IDLE;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.q_sign    = q_sign_q;
  assign bus.r_sign    = r_sign_q;
  assign bus.zflag     = zflag_q;
  assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider (WIDTH=8): results packed as
// {quotient, q_sign, remainder, r_sign, zflag, dbz}.
module tb_signed_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  signed_divider_if #(.WIDTH(W)) bus ();

  signed_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [18:0] res;
  assign res = {bus.quotient, bus.q_sign, bus.remainder, bus.r_sign, bus.zflag, bus.dbz};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [18:0] exp;
  } vec_t;

  // Pulse start for one cycle, return cycles from accept edge to done (-1 on
  // timeout), then step one more cycle so the FSM is back in IDLE.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (res !== {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_outputs got %h want %h", res, {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    int lat;
    run_div(8'd100, 8'd7, lat);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    checks++;
    if (res !== {8'd14, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_100_7 got %h want %h", res, {8'd14, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0});
    end
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle got done/busy %b want 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_signs();
    vec_t v[11];
    int   lat;
    v[0]  = '{8'(-100), 8'd7,     {8'd14,  1'b1, 7'd2,   1'b1, 1'b0, 1'b0}};
    v[1]  = '{8'(-100), 8'(-7),   {8'd14,  1'b0, 7'd2,   1'b1, 1'b0, 1'b0}};
    v[2]  = '{8'd100,   8'(-7),   {8'd14,  1'b1, 7'd2,   1'b0, 1'b0, 1'b0}};
    v[3]  = '{8'h80,    8'hFF,    {8'h80,  1'b0, 7'd0,   1'b0, 1'b0, 1'b0}};
    v[4]  = '{8'h80,    8'd1,     {8'h80,  1'b1, 7'd0,   1'b0, 1'b0, 1'b0}};
    v[5]  = '{8'd127,   8'h80,    {8'd0,   1'b0, 7'd127, 1'b0, 1'b1, 1'b0}};
    v[6]  = '{8'h80,    8'h80,    {8'd1,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0}};
    v[7]  = '{8'h80,    8'd7,     {8'd18,  1'b1, 7'd2,   1'b1, 1'b0, 1'b0}};
    v[8]  = '{8'd5,     8'(-9),   {8'd0,   1'b0, 7'd5,   1'b0, 1'b1, 1'b0}};
    v[9]  = '{8'(-5),   8'd9,     {8'd0,   1'b0, 7'd5,   1'b1, 1'b1, 1'b0}};
    v[10] = '{8'(-1),   8'd2,     {8'd0,   1'b0, 7'd1,   1'b1, 1'b1, 1'b0}};
    foreach (v[i]) begin
      run_div(v[i].a, v[i].b, lat);
      checks++;
      if (lat !== W || res !== v[i].exp) begin
        errors++;
        $display("FAIL signs_vec%0d %0d/%0d got %h lat %0d want %h lat %0d",
                 i, $signed(v[i].a), $signed(v[i].b), res, lat, v[i].exp, W);
      end
    end
  endtask

  task automatic test_dbz();
    int lat;
    run_div(8'd37, 8'd0, lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL dbz_latency got %0d want 0", lat); end
    checks++;
    if (res !== {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL dbz_37_0 got %h want %h", res, {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1});
    end
    run_div(8'd9, 8'd3, lat);
    checks++;
    if (lat !== W || res !== {8'd3, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL dbz_clear_9_3 got %h lat %0d want %h lat %0d",
                         res, lat, {8'd3, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}, W);
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignored_busy got %b want 1", bus.busy); end
    bus.dividend = 8'd50; bus.divisor = 8'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 3; n < 40; n++) begin
      if (bus.done) begin lat = n; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== W || res !== {8'd14, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ignored_start got %h lat %0d want %h lat %0d",
                         res, lat, {8'd14, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0}, W);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    bus.dividend = 8'd9; bus.divisor = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) break;
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || res !== {8'd3, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_first got done %b res %h want done 1 res %h",
                         bus.done, res, {8'd3, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0});
    end
    // start raised in the DONE cycle and held into IDLE
    bus.dividend = 8'(-100); bus.divisor = 8'd7; bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL b2b_done_cycle_ignored got busy/done %b want 00", {bus.busy, bus.done});
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", bus.busy); end
    for (int n = 0; n < 40; n++) begin
      if (bus.done) begin lat = n; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== W || res !== {8'd14, 1'b1, 7'd2, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_second got %h lat %0d want %h lat %0d",
                         res, lat, {8'd14, 1'b1, 7'd2, 1'b1, 1'b0, 1'b0}, W);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL midrst_busy_done got %b want 00", {bus.busy, bus.done});
    end
    checks++;
    if (res !== {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midrst_outputs got %h want %h", res, {8'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0});
    end
    for (int n = 0; n < 12; n++) begin
      if (bus.done || bus.busy) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_dbz();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
